// File: rtl/mtrx_pkg.sv
// Shared opcodes, FSM states and index helpers for the 4x4 transform-matrix accumulator.
package mtrx_pkg;

  localparam logic [1:0] OP_IDENTITY  = 2'd0;
  localparam logic [1:0] OP_TRANSLATE = 2'd1;
  localparam logic [1:0] OP_SCALE     = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DONE
  } state_t;

  function automatic logic [31:0] fx_one(input int frac);
    return 32'd1 << frac;
  endfunction

  // Element slot of (r,c) on the row-major bus; (0,0) lands in the MSBs.
  function automatic int pidx(input int r, input int c);
    return 15 - (4 * r + c);
  endfunction

endpackage

// File: rtl/fx_shift_sat.sv
// Arithmetic right shift by FRAC of a wide accumulator, then clamp to a signed WIDTH-bit result.
module fx_shift_sat #(
  parameter int WIDTH = 21,
  parameter int FRAC  = 10
) (
  input  logic signed [2*WIDTH+1:0] acc,
  output logic signed [WIDTH-1:0]   val,
  output logic                      sat
);

  localparam int AW = 2 * WIDTH + 2;
  localparam logic signed [AW-1:0] MAX_V = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [AW-1:0] shifted;

  always_comb begin
    shifted = acc >>> FRAC;
    sat     = 1'b0;
    val     = shifted[WIDTH-1:0];
    if (shifted > MAX_V) begin
      val = MAX_V[WIDTH-1:0];
      sat = 1'b1;
    end else if (shifted < MIN_V) begin
      val = MIN_V[WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/mtrx_accum.sv
// Fixed-point 4x4 model-matrix accumulator: post-multiplies by identity/translate/scale
// elementary matrices through one shared multiply-accumulate path.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// MAC     | 12 multiply steps, row = step/3, column = step%3
// DONE    | publish pulse visible, return to IDLE next cycle
module mtrx_accum
  import mtrx_pkg::*;
#(
  parameter int WIDTH = 21,
  parameter int FRAC  = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic signed [WIDTH-1:0] cmd_x,
  input  logic signed [WIDTH-1:0] cmd_y,
  input  logic signed [WIDTH-1:0] cmd_z,
  output logic [16*WIDTH-1:0]     mtrx_out,
  output logic                    mtrx_valid,
  output logic                    ovf,
  output logic                    busy
);

  localparam int AW = 2 * WIDTH + 2;
  localparam logic [31:0] ONE32 = fx_one(FRAC);
  localparam logic signed [WIDTH-1:0] ONE = ONE32[WIDTH-1:0];

  state_t                  state;
  logic [1:0]              op_q, row, col;
  logic signed [WIDTH-1:0] x_q, y_q, z_q;
  logic signed [WIDTH-1:0] w     [16];
  logic signed [WIDTH-1:0] w_nxt [16];
  logic signed [WIDTH-1:0] opnd, w_sel, w_r3, sat_val;
  logic signed [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic signed [AW-1:0]    acc, sum, prod_ext;
  logic                    sat_hit, step_write, step_sat, sticky, accept, last_step;
  logic [3:0]              idx;
  logic [16*WIDTH-1:0]     w_pack, id_pack;

  assign accept     = cmd_valid && cmd_ready;
  assign busy       = ~cmd_ready;
  assign idx        = {row, 2'b00} | {2'b00, col};
  assign last_step  = (row == 2'd3) && (col == 2'd2);
  assign step_write = (state == ST_MAC) && ((op_q == OP_SCALE) || (col == 2'd2));
  assign step_sat   = step_write && sat_hit;

  always_comb begin
    case (col)
      2'd0:    opnd = x_q;
      2'd1:    opnd = y_q;
      default: opnd = z_q;
    endcase
    w_sel    = w[idx];
    w_r3     = w[{row, 2'b11}];
    a_ext    = {{WIDTH{w_sel[WIDTH-1]}}, w_sel};
    b_ext    = {{WIDTH{opnd[WIDTH-1]}}, opnd};
    prod     = a_ext * b_ext;
    prod_ext = {{2{prod[2*WIDTH-1]}}, prod};
    // Translate seeds the row sum with W[r][3]*ONE so column 3 ends up as the full dot product.
    if (op_q == OP_SCALE)
      sum = prod_ext;
    else if (col == 2'd0)
      sum = ({{(AW-WIDTH){w_r3[WIDTH-1]}}, w_r3} << FRAC) + prod_ext;
    else
      sum = acc + prod_ext;
  end

  fx_shift_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_shift_sat (
    .acc (sum),
    .val (sat_val),
    .sat (sat_hit)
  );

  always_comb begin
    for (int k = 0; k < 16; k++) w_nxt[k] = w[k];
    if (accept && (cmd_op == OP_IDENTITY)) begin
      for (int k = 0; k < 16; k++) w_nxt[k] = (k % 5 == 0) ? ONE : '0;
    end else if (step_write) begin
      if (op_q == OP_SCALE) w_nxt[idx] = sat_val;
      else                  w_nxt[{row, 2'b11}] = sat_val;
    end
  end

  for (genvar gr = 0; gr < 4; gr++) begin : g_row
    for (genvar gc = 0; gc < 4; gc++) begin : g_col
      assign w_pack[pidx(gr, gc)*WIDTH +: WIDTH]  = w_nxt[gr*4+gc];
      assign id_pack[pidx(gr, gc)*WIDTH +: WIDTH] = (gr == gc) ? ONE : '0;
    end
  end

  // Outputs are loaded from w_nxt on entry to DONE so the pulse lines up with the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cmd_ready  <= 1'b1;
      mtrx_valid <= 1'b0;
      ovf        <= 1'b0;
      sticky     <= 1'b0;
      op_q       <= OP_IDENTITY;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      row        <= '0;
      col        <= '0;
      acc        <= '0;
      mtrx_out   <= id_pack;
      for (int k = 0; k < 16; k++) w[k] <= (k % 5 == 0) ? ONE : '0;
    end else begin
      for (int k = 0; k < 16; k++) w[k] <= w_nxt[k];
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q      <= cmd_op;
            x_q       <= cmd_x;
            y_q       <= cmd_y;
            z_q       <= cmd_z;
            row       <= '0;
            col       <= '0;
            cmd_ready <= 1'b0;
            if ((cmd_op == OP_TRANSLATE) || (cmd_op == OP_SCALE)) begin
              state <= ST_MAC;
            end else begin
              state      <= ST_DONE;
              mtrx_out   <= w_pack;
              mtrx_valid <= 1'b1;
              ovf        <= 1'b0;
              sticky     <= 1'b0;
            end
          end
        end
        ST_MAC: begin
          acc <= sum;
          if (last_step) begin
            state      <= ST_DONE;
            mtrx_out   <= w_pack;
            mtrx_valid <= 1'b1;
            ovf        <= sticky | step_sat;
            sticky     <= 1'b0;
          end else begin
            sticky <= sticky | step_sat;
            if (col == 2'd2) begin
              col <= '0;
              row <= row + 2'd1;
            end else begin
              col <= col + 2'd1;
            end
          end
        end
        ST_DONE: begin
          mtrx_valid <= 1'b0;
          ovf        <= 1'b0;
          cmd_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mtrx_accum.sv
// Self-checking bench for mtrx_accum: directed vector table, random commands against a
// matrix-product reference model, and hand-written reset/back-to-back sequences.
module tb_mtrx_accum;
  import mtrx_pkg::*;

  localparam int W  = 21;
  localparam int F  = 10;
  localparam int MW = 16 * W;
  localparam longint ONE_L = 1024;
  localparam longint MAXL  = (64'sd1 << 20) - 1;
  localparam longint MINL  = -(64'sd1 << 20);

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                cmd_valid = 1'b0;
  logic [1:0]          cmd_op = 2'd0;
  logic signed [W-1:0] cmd_x = '0, cmd_y = '0, cmd_z = '0;
  logic                cmd_ready, mtrx_valid, ovf, busy;
  logic [MW-1:0]       mtrx_out;

  int            n_pass = 0;
  int            n_total = 0;
  longint        m [16];
  logic [MW-1:0] last_pub;

  always #5 clk = ~clk;

  mtrx_accum #(.WIDTH(W), .FRAC(F)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_z      (cmd_z),
    .mtrx_out   (mtrx_out),
    .mtrx_valid (mtrx_valid),
    .ovf        (ovf),
    .busy       (busy)
  );

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Reference model: M <- sat((M * E) >>> FRAC) over all 16 elements, E the elementary matrix.
  function automatic logic [MW-1:0] pack_m();
    logic [MW-1:0] p;
    p = '0;
    for (int k = 0; k < 16; k++) p[(15-k)*W +: W] = m[k][W-1:0];
    return p;
  endfunction

  task automatic model_id();
    for (int k = 0; k < 16; k++) m[k] = (k % 5 == 0) ? ONE_L : 0;
  endtask

  task automatic model_apply(input logic [1:0] op, input longint x, y, z, output bit ov);
    longint e [4][4];
    longint nm [16];
    longint s, v;
    ov = 1'b0;
    if (op == OP_IDENTITY) begin
      model_id();
      return;
    end
    if (op != OP_TRANSLATE && op != OP_SCALE) return;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) e[r][c] = (r == c) ? ONE_L : 0;
    if (op == OP_TRANSLATE) begin
      e[0][3] = x; e[1][3] = y; e[2][3] = z;
    end else begin
      e[0][0] = x; e[1][1] = y; e[2][2] = z;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += m[r*4+k] * e[k][c];
        v = s >>> F;
        if (v > MAXL) begin v = MAXL; ov = 1'b1; end
        else if (v < MINL) begin v = MINL; ov = 1'b1; end
        nm[r*4+c] = v;
      end
    for (int k = 0; k < 16; k++) m[k] = nm[k];
  endtask

  typedef struct {
    logic [1:0] op;
    longint     x, y, z;
    longint     d0, d1, d2, d3;
    longint     c0, c1, c2;
    bit         ov;
  } vec_t;

  // Every table result is affine-diagonal: diagonal d*, column 3 c*, zero elsewhere.
  function automatic logic [MW-1:0] vec_mat(input vec_t v);
    longint d [4];
    longint c3 [4];
    longint e;
    logic [MW-1:0] p;
    d  = '{v.d0, v.d1, v.d2, v.d3};
    c3 = '{v.c0, v.c1, v.c2, v.d3};
    p  = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        e = (r == c) ? d[r] : ((c == 3) ? c3[r] : 0);
        p[(15-(4*r+c))*W +: W] = e[W-1:0];
      end
    return p;
  endfunction

  task automatic run_cmd(input logic [1:0] op, input longint x, y, z,
                         input logic [MW-1:0] exp_m, input bit exp_ov, input string tag);
    int n;
    int exp_lat;
    bit held;
    n = 0;
    while (!cmd_ready && n < 40) begin @(negedge clk); n++; end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = x[W-1:0];
    cmd_y     = y[W-1:0];
    cmd_z     = z[W-1:0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_x     = W'($urandom);
    cmd_y     = W'($urandom);
    cmd_z     = W'($urandom);
    exp_lat = (op == OP_TRANSLATE || op == OP_SCALE) ? 13 : 1;
    held = 1'b1;
    n = 0;
    forever begin
      @(negedge clk); n++;
      if (mtrx_valid || n >= 40) break;
      if (cmd_ready || mtrx_out !== last_pub) held = 1'b0;
    end
    chk({tag, ".lat"}, MW'(n), MW'(exp_lat));
    if (exp_lat == 13) chk({tag, ".hold"}, MW'(held), MW'(1));
    chk({tag, ".mat"}, mtrx_out, exp_m);
    chk({tag, ".ovf"}, MW'(ovf), MW'(exp_ov));
    @(negedge clk);
    chk({tag, ".post"}, MW'({mtrx_valid, cmd_ready, busy}), MW'(3'b010));
    last_pub = exp_m;
  endtask

  initial begin
    vec_t tbl [7];
    bit ov;
    int n, vn, rn, nvalid;
    longint x, y, z;
    logic [1:0] op;
    logic signed [W-1:0] t;
    logic [MW-1:0] id_m, exp_m;

    tbl[0] = '{OP_IDENTITY,  0, 0, 0, ONE_L, ONE_L, ONE_L, ONE_L, 0, 0, 0, 1'b0};
    tbl[1] = '{OP_TRANSLATE, 'h1400, -'hC00, 'h1C00, ONE_L, ONE_L, ONE_L, ONE_L,
               'h1400, -'hC00, 'h1C00, 1'b0};
    tbl[2] = '{OP_SCALE, 'h800, 'h200, 'h400, 'h800, 'h200, 'h400, ONE_L,
               'h1400, -'hC00, 'h1C00, 1'b0};
    tbl[3] = '{OP_IDENTITY,  0, 0, 0, ONE_L, ONE_L, ONE_L, ONE_L, 0, 0, 0, 1'b0};
    tbl[4] = '{OP_SCALE, 'hFFFFF, 'hFFFFF, 'hFFFFF, 'hFFFFF, 'hFFFFF, 'hFFFFF, ONE_L,
               0, 0, 0, 1'b0};
    tbl[5] = '{OP_SCALE, 'hFFFFF, 'hFFFFF, 'hFFFFF, 'hFFFFF, 'hFFFFF, 'hFFFFF, ONE_L,
               0, 0, 0, 1'b1};
    tbl[6] = '{2'd3, 'h777, 'h123, -'h55, 'hFFFFF, 'hFFFFF, 'hFFFFF, ONE_L, 0, 0, 0, 1'b0};

    model_id();
    id_m = pack_m();
    last_pub = id_m;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst.async_mat", mtrx_out, id_m);
    chk("rst.async_flags", MW'({mtrx_valid, cmd_ready, busy, ovf}), MW'(4'b0100));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.mat", mtrx_out, id_m);
    chk("rst.flags", MW'({mtrx_valid, cmd_ready, busy, ovf}), MW'(4'b0100));

    for (int i = 0; i < 7; i++) begin
      model_apply(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].z, ov);
      run_cmd(tbl[i].op, tbl[i].x, tbl[i].y, tbl[i].z, vec_mat(tbl[i]), tbl[i].ov,
              $sformatf("tbl%0d", i));
    end

    // Reset in the middle of a TRANSLATE: no publish, identity at once.
    cmd_valid = 1'b1; cmd_op = OP_TRANSLATE;
    cmd_x = W'('h2000); cmd_y = W'('h300); cmd_z = W'(-'h400);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.mat", mtrx_out, id_m);
    chk("midrst.flags", MW'({mtrx_valid, cmd_ready, busy}), MW'(3'b010));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mtrx_valid) nvalid++;
    end
    chk("midrst.no_valid", MW'(nvalid), MW'(0));
    chk("midrst.ready", MW'(cmd_ready), MW'(1));
    chk("midrst.mat_after", mtrx_out, id_m);
    model_id();
    last_pub = id_m;

    // Random commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      n = int'($urandom_range(0, 9));
      op = (n == 0) ? OP_IDENTITY : (n == 1) ? 2'd3 : (n < 6) ? OP_TRANSLATE : OP_SCALE;
      if ($urandom_range(0, 7) == 0) begin
        t = W'($urandom); x = t;
        t = W'($urandom); y = t;
        t = W'($urandom); z = t;
      end else if (op == OP_SCALE) begin
        x = longint'(int'($urandom_range(0, 4096)) - 2048);
        y = longint'(int'($urandom_range(0, 4096)) - 2048);
        z = longint'(int'($urandom_range(0, 4096)) - 2048);
      end else begin
        x = longint'(int'($urandom_range(0, 1 << 19)) - (1 << 18));
        y = longint'(int'($urandom_range(0, 1 << 19)) - (1 << 18));
        z = longint'(int'($urandom_range(0, 1 << 19)) - (1 << 18));
      end
      model_apply(op, x, y, z, ov);
      run_cmd(op, x, y, z, pack_m(), ov, $sformatf("rnd%0d", i));
    end

    // cmd_valid held high: TRANSLATE, then IDENTITY queued while busy.
    while (!cmd_ready) @(negedge clk);
    x = 'h1800; y = -'h2400; z = 'h0C00;
    model_apply(OP_TRANSLATE, x, y, z, ov);
    exp_m = pack_m();
    cmd_valid = 1'b1; cmd_op = OP_TRANSLATE;
    cmd_x = x[W-1:0]; cmd_y = y[W-1:0]; cmd_z = z[W-1:0];
    @(posedge clk); #1;
    cmd_op = OP_IDENTITY;
    cmd_x = W'('h7FFF); cmd_y = W'('h1234); cmd_z = W'('h4321);
    n = 0; vn = 0; rn = 0;
    while (n < 30) begin
      @(negedge clk); n++;
      if (mtrx_valid && vn == 0) begin
        vn = n;
        chk("b2b.translate_mat", mtrx_out, exp_m);
      end
      if (cmd_ready) begin rn = n; break; end
    end
    chk("b2b.valid_at", MW'(vn), MW'(13));
    chk("b2b.ready_at", MW'(rn), MW'(14));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b.identity", {mtrx_valid, mtrx_out[MW-2:0]}, {1'b1, id_m[MW-2:0]});
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mtrx_accum.md
# mtrx_accum

Sequential fixed-point 4x4 transform-matrix accumulator for the geometry front end. It holds a current model matrix, starting at identity, and applies one command at a time by post-multiplying with an elementary matrix. Commands are load-identity, translate and scale. It uses a single time-shared multiply-accumulate path and publishes the updated matrix atomically on a row-major packed bus for the vertex-transform stage.

## Interface
- WIDTH, default 21: signed element width, in bits.
- FRAC, default 10: fractional bits. ONE = 1<<FRAC (0x400 at the default).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command. High only in IDLE.
- cmd_op  in  2  command opcode: 0 IDENTITY, 1 TRANSLATE, 2 SCALE, 3 reserved.
- cmd_x, cmd_y, cmd_z  in  WIDTH each  signed fixed-point operands: tx/ty/tz for TRANSLATE, sx/sy/sz for SCALE.
- mtrx_out  out  16*WIDTH  published matrix, row-major.
  - Element (r,c), k=4r+c, sits at bits [(15-k)*WIDTH +: WIDTH], so element (0,0) is in the MSBs.
- mtrx_valid  out  1  one-cycle pulse; mtrx_out changes in this same cycle.
- ovf  out  1  valid only with mtrx_valid: 1 if any element saturated during this command.
- busy  out  1  equals ~cmd_ready.

## Operation
- Reset values:
  - working array and mtrx_out = identity (ONE on the diagonal, 0 elsewhere).
  - mtrx_valid=0, ovf=0, cmd_ready=1, state=IDLE.
- Handshake:
  - A command is accepted on a cycle with cmd_valid && cmd_ready; operands are latched then.
  - Inputs are ignored while busy.
- States: IDLE, MAC, DONE.
  - IDLE: accept a command.
    - IDENTITY or reserved op: go to DONE. IDENTITY loads identity into the working array; the reserved op leaves it unchanged.
    - TRANSLATE or SCALE: go to MAC with step counter = 0.
  - MAC: 12 steps (counter 0..11), one multiply per step.
    - SCALE, step s: row r = s/3, column c = s%3. W[r][c] ← sat((W[r][c]*S_c) >>> FRAC), where S = (sx, sy, sz).
    - TRANSLATE, step s: row r = s/3, j = s%3.
      - j = 0: acc = (W[r][3] <<< FRAC) + W[r][0]*tx.
      - j = 1: acc += W[r][1]*ty.
      - j = 2: acc += W[r][2]*tz, then W[r][3] ← sat(acc >>> FRAC).
    - Go to DONE after step 11.
  - DONE: mtrx_out ← working array; pulse mtrx_valid; ovf = the sticky saturation flag; clear the flag; go to IDLE.
- Arithmetic:
  - Products are full 2*WIDTH signed; the accumulator is 2*WIDTH+2 signed.
  - >>> is an arithmetic shift (truncation toward −∞).
  - sat() clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1] and sets the sticky flag when it clamps.
- In-place writes are safe: each source element is read before, or is not, the element being written.
- Row 3 is processed like the others. For affine inputs it stays (0,0,0,ONE).

## Timing
- Acceptance at cycle t:
  - IDENTITY/reserved: DONE and mtrx_valid at t+1; cmd_ready high again at t+2.
  - TRANSLATE/SCALE: MAC during t+1..t+12; DONE and mtrx_valid at t+13; cmd_ready high again at t+14.
- mtrx_out is stable between mtrx_valid pulses. Intermediate MAC results are never visible on it.
- rst_n asserted at any point, including mid-MAC:
  - all state returns to the reset values immediately (asynchronously);
  - the in-flight command is discarded and no mtrx_valid is issued.

## Structure
- Package mtrx_pkg holds:
  - the opcode constants OP_IDENTITY, OP_TRANSLATE, OP_SCALE;
  - the state enum;
  - the function computing ONE from FRAC;
  - the packed-index helper for (r,c).
- One sub-module, fx_shift_sat: parametrised on WIDTH and FRAC. Takes a wide signed accumulator and returns the shifted, saturated WIDTH-bit value plus a saturation flag. Instantiated once in mtrx_accum.

## Test plan
Defaults throughout: WIDTH=21, FRAC=10.
- Reset → mtrx_out is identity with diagonal 0x000400, mtrx_valid=0, cmd_ready=1.
- From identity, TRANSLATE (0x001400, −0x000C00, 0x001C00) accepted at t:
  - cmd_ready=0 during t+1..t+13;
  - mtrx_valid pulses at t+13;
  - column 3 = (0x001400, 0x1FF400, 0x001C00, 0x000400); ovf=0.
- Then SCALE (0x000800, 0x000200, 0x000400) → diagonal = (0x000800, 0x000200, 0x000400, 0x000400); column 3 unchanged.
- SCALE (0x0FFFFF, 0x0FFFFF, 0x0FFFFF) issued twice from identity:
  - first result: diagonal (0,0), (1,1), (2,2) = 0x0FFFFF with ovf=0;
  - second result: those entries stay at 0x0FFFFF (clamped) with ovf=1.
- cmd_valid held high with TRANSLATE then IDENTITY queued → the second command is accepted exactly at t+14; identity is restored at t+15.
- rst_n low at t+6 of a TRANSLATE → mtrx_out is identity at once, no mtrx_valid, cmd_ready=1 after release.
